// File: rtl/rle_enc_param.sv
// Parametrised run-length encoder with per-channel compare mask, flush and a
// FWFT output FIFO. Optional RLE_STATS_EN adds sample/word counters.
module rle_enc_param #(
  parameter int DW      = 16,
  parameter int FIFO_AW = 3
) (
  input  logic          core_clk,
  input  logic          core_rst,
  input  logic [DW-1:0] capture_data,
  input  logic          capture_valid,
  input  logic [DW-2:0] capture_mask,
  input  logic          flush,
  output logic [DW-1:0] rle_data,
  output logic          rle_valid,
  input  logic          rle_ready,
  output logic          overflow,
  output logic          idle
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]   sample_count,
  output logic [31:0]   word_count
`endif
);

  localparam int SW    = DW - 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [SW-1:0]      MAX_CNT  = '1;
  localparam logic [SW-1:0]      CNT_LAST = MAX_CNT - 1'b1;
  localparam logic [FIFO_AW+1:0] DEPTH_W  = (FIFO_AW + 2)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Handshake: a word moves to the consumer on any edge where rle_valid and
  // rle_ready are both high; rle_data is held while rle_valid & ~rle_ready.

  state_t        state, state_nxt;
  logic [SW-1:0] old_q, old_nxt;
  logic [SW-1:0] cnt_q, cnt_nxt;
  logic [DW-1:0] push_w0, push_w1;
  logic [1:0]    push_n;
  logic [SW-1:0] sample;
  logic          sample_eq;
  logic          unused_msb;

  assign sample     = capture_data[SW-1:0];
  assign unused_msb = capture_data[DW-1];
  assign sample_eq  = ((sample ^ old_q) & capture_mask) == '0;

  always_comb begin
    state_nxt = state;
    old_nxt   = old_q;
    cnt_nxt   = cnt_q;
    push_w0   = '0;
    push_w1   = '0;
    push_n    = 2'd0;

    if (capture_valid) begin
      if (state == ST_IDLE) begin
        push_w0   = {1'b0, sample};
        push_n    = 2'd1;
        old_nxt   = sample;
        cnt_nxt   = '0;
        state_nxt = ST_RUN;
      end else if (sample_eq) begin
        // A saturated run is emitted early so a count word never wraps to 0.
        if (cnt_q == CNT_LAST) begin
          push_w0 = {1'b1, MAX_CNT};
          push_n  = 2'd1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q != '0) begin
          push_w0 = {1'b1, cnt_q};
          push_w1 = {1'b0, sample};
          push_n  = 2'd2;
        end else begin
          push_w0 = {1'b0, sample};
          push_n  = 2'd1;
        end
        old_nxt = sample;
        cnt_nxt = '0;
      end
    end

    // Flush sees the post-sample count, so at most two words per cycle.
    if (flush) begin
      if (state_nxt == ST_RUN && cnt_nxt != '0) begin
        if (push_n == 2'd0) begin
          push_w0 = {1'b1, cnt_nxt};
        end else begin
          push_w1 = {1'b1, cnt_nxt};
        end
        push_n = push_n + 2'd1;
      end
      cnt_nxt   = '0;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state <= ST_IDLE;
      old_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      old_q <= old_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr, fill;
  logic [FIFO_AW+1:0] free_slots;
  logic [FIFO_AW-1:0] wr_idx0, wr_idx1;
  logic               fifo_empty, pop, push_fits, do_push;

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign pop        = rle_valid & rle_ready;
  assign free_slots = DEPTH_W - {1'b0, fill} + {{(FIFO_AW + 1){1'b0}}, pop};
  // All words of a cycle are written together or dropped together.
  assign push_fits  = {{FIFO_AW{1'b0}}, push_n} <= free_slots;
  assign do_push    = (push_n != 2'd0) && push_fits;
  assign wr_idx0    = wr_ptr[FIFO_AW-1:0];
  assign wr_idx1    = wr_idx0 + 1'b1;

  always_ff @(posedge core_clk) begin
    if (do_push) begin
      mem[wr_idx0] <= push_w0;
      if (push_n == 2'd2) begin
        mem[wr_idx1] <= push_w1;
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{(FIFO_AW - 1){1'b0}}, push_n};
      end
      rd_ptr <= rd_ptr + {{FIFO_AW{1'b0}}, pop};
      if (push_n != 2'd0 && !push_fits) begin
        overflow <= 1'b1;
      end
    end
  end

  assign rle_valid = ~fifo_empty;
  assign rle_data  = rle_valid ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
  assign idle      = (state == ST_IDLE) && fifo_empty;

`ifdef RLE_STATS_EN
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      sample_count <= '0;
      word_count   <= '0;
    end else begin
      sample_count <= sample_count + 32'(capture_valid);
      word_count   <= word_count + 32'(pop);
    end
  end
`endif

endmodule

// File: tb/tb_rle_enc_param.sv
// Randomised and directed bench for rle_enc_param (DW=16, 4-deep FIFO);
// covers the RLE_STATS_EN counters when that macro is defined.
module tb_rle_enc_param;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int SW    = DW - 1;
  localparam int MAXC  = (1 << SW) - 1;

  logic          core_clk = 1'b0;
  logic          core_rst;
  logic [DW-1:0] capture_data;
  logic          capture_valid;
  logic [DW-2:0] capture_mask;
  logic          flush;
  logic [DW-1:0] rle_data;
  logic          rle_valid;
  logic          rle_ready;
  logic          overflow;
  logic          idle;
`ifdef RLE_STATS_EN
  logic [31:0]   sample_count;
  logic [31:0]   word_count;
`endif

  always #5 core_clk = ~core_clk;

  rle_enc_param #(.DW(DW), .FIFO_AW(AW)) dut (
    .core_clk      (core_clk),
    .core_rst      (core_rst),
    .capture_data  (capture_data),
    .capture_valid (capture_valid),
    .capture_mask  (capture_mask),
    .flush         (flush),
    .rle_data      (rle_data),
    .rle_valid     (rle_valid),
    .rle_ready     (rle_ready),
    .overflow      (overflow),
    .idle          (idle)
`ifdef RLE_STATS_EN
    ,
    .sample_count  (sample_count),
    .word_count    (word_count)
`endif
  );

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] dir_q[$];
  int checks = 0;
  int errors = 0;

  // reference: last literal, extra-sample count, run flag, FIFO occupancy
  int unsigned   m_old, m_cnt;
  bit            m_run;
  int            m_occ;
  bit            m_ovf;
  logic [SW-1:0] mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lit_word(input int unsigned s);
    logic [SW-1:0] v;
    v = s[SW-1:0];
    return {1'b0, v};
  endfunction

  function automatic logic [DW-1:0] cnt_word(input int unsigned n);
    logic [SW-1:0] v;
    v = n[SW-1:0];
    return {1'b1, v};
  endfunction

  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit f, input bit rdy);
    logic [DW-1:0] w[$];
    int unsigned s, mk;
    int free;
    int pop;
    s  = int'(d[SW-1:0]);
    mk = int'(mask);
    if (v) begin
      if (!m_run) begin
        w.push_back(lit_word(s));
        m_old = s; m_cnt = 0; m_run = 1;
      end else if ((s & mk) == (m_old & mk)) begin
        m_cnt++;
        if (m_cnt == MAXC) begin
          w.push_back(cnt_word(MAXC));
          m_cnt = 0;
        end
      end else begin
        if (m_cnt != 0) w.push_back(cnt_word(m_cnt));
        w.push_back(lit_word(s));
        m_old = s; m_cnt = 0;
      end
    end
    if (f) begin
      if (m_run && m_cnt != 0) w.push_back(cnt_word(m_cnt));
      m_cnt = 0; m_run = 0;
    end
    pop  = (m_occ > 0 && rdy) ? 1 : 0;
    free = DEPTH - m_occ + pop;
    if (w.size() > free) begin
      m_ovf = 1;
    end else begin
      foreach (w[i]) exp_q.push_back(w[i]);
      m_occ += w.size();
    end
    m_occ -= pop;
  endtask

  // One clock: check the state left by the previous edge, drive, step model.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit f, input bit rdy);
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("idle", {31'd0, idle}, {31'd0, (!m_run && m_occ == 0)});
    capture_valid = v;
    capture_data  = d;
    flush         = f;
    rle_ready     = rdy;
    capture_mask  = mask;
    model_step(v, d, f, rdy);
    @(posedge core_clk);
    #1;
  endtask

  task automatic do_reset();
    core_rst      = 1'b1;
    capture_valid = 1'b0;
    flush         = 1'b0;
    rle_ready     = 1'b0;
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    exp_q.delete();
    m_old = 0; m_cnt = 0; m_run = 0; m_occ = 0; m_ovf = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_occ > 0 && n < 64) begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("drain_bound", n < 64, 1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic compare_got(input string name);
    check({name, "_len"}, got_q.size(), dir_q.size());
    foreach (dir_q[i]) begin
      if (i < got_q.size()) check(name, got_q[i], dir_q[i]);
    end
  endtask

  task automatic random_phase(input int n, input int ready_pct);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 199) == 0) mask = SW'($urandom);
      if ($urandom_range(0, 9) == 0) d = DW'($urandom);
      else d = {DW'($urandom_range(0, 1)) << (DW - 1)} | DW'($urandom_range(0, 3));
      cyc($urandom_range(0, 9) < 8, d, $urandom_range(0, 49) == 0,
          $urandom_range(0, 99) < ready_pct);
    end
  endtask

  // Monitor: pops the expected queue on every accepted word.
  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] e;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge core_clk);
      if (core_rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'd0, rle_valid}, 32'd1);
          check("stall_data", rle_data, prev_data);
        end
        if (rle_valid && rle_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", rle_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("word", rle_data, e);
          end
          got_q.push_back(rle_data);
        end
        prev_stall = rle_valid && !rle_ready;
        prev_data  = rle_data;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    core_rst      = 1'b1;
    capture_data  = '0;
    capture_valid = 1'b0;
    capture_mask  = '1;
    flush         = 1'b0;
    rle_ready     = 1'b0;
    mask          = '1;
    m_old = 0; m_cnt = 0; m_run = 0; m_occ = 0; m_ovf = 0;
    repeat (2) @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    check("rst_valid", {31'd0, rle_valid}, 32'd0);
    check("rst_data", rle_data, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);

    // run of 5 with a gap, new value, flush
    mask = 15'h7FFF;
    got_q.delete();
    repeat (3) cyc(1'b1, 16'h0005, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    repeat (2) cyc(1'b1, 16'h0005, 1'b0, 1'b1);
    cyc(1'b1, 16'h0007, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    drain();
    dir_q = '{16'h0005, 16'h8004, 16'h0007};
    compare_got("t1_word");
    check("t1_idle", {31'd0, idle}, 32'd1);
`ifdef RLE_STATS_EN
    check("t6_sample_count", sample_count, 32'd6);
    check("t6_word_count", word_count, 32'd3);
`endif

    // saturating run
    got_q.delete();
    repeat (32769) cyc(1'b1, 16'h0001, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    drain();
    dir_q = '{16'h0001, 16'hFFFF, 16'h8001};
    compare_got("t2_word");

    // masked compare
    mask = 15'h7FFE;
    got_q.delete();
    cyc(1'b1, 16'h0002, 1'b0, 1'b1);
    cyc(1'b1, 16'h0003, 1'b0, 1'b1);
    cyc(1'b1, 16'h0002, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    drain();
    dir_q = '{16'h0002, 16'h8002};
    compare_got("t3_word");

    random_phase(2000, 60);
    cyc(1'b0, '0, 1'b1, 1'b1);
    drain();

    // overflow with a stalled consumer
    do_reset();
    mask = 15'h7FFF;
    got_q.delete();
    for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    drain();
    dir_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    compare_got("t4_word");
    cyc(1'b0, '0, 1'b1, 1'b1);

    // reset mid-run discards pending count and FIFO contents
    do_reset();
    repeat (4) cyc(1'b1, 16'h0009, 1'b0, 1'b0);
    do_reset();
    check("t5_valid", {31'd0, rle_valid}, 32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd0);
    got_q.delete();
    cyc(1'b1, 16'h0009, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    drain();
    dir_q = '{16'h0009};
    compare_got("t5_word");

    random_phase(1500, 90);
    cyc(1'b0, '0, 1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rle_enc_param.md
Name: rle_enc_param

Overview:
Parametrised run-length encoder for the capture path. It sits between the sampler and the SDRAM/USB packer. It replaces fixed 16-bit, always-valid RLE with configurable width, a per-channel compare mask, input qualification, end-of-capture flush, an output FIFO with ready/valid backpressure, and overflow reporting. Word format: MSB=0 is a literal {0,sample[DW-2:0]}; MSB=1 is a count {1,n}, where n is the number of extra samples equal to the last literal.

Parameters:
DW, 16, output word width; sample field is DW-1 bits; DW>=4
FIFO_AW, 3, output FIFO address width; depth 2^FIFO_AW; FIFO_AW>=2

Ports:
core_clk  in  1  clock
core_rst  in  1  reset, synchronous, active-high
capture_data  in  DW  sample; bit DW-1 ignored
capture_valid  in  1  qualifies capture_data this cycle
capture_mask  in  DW-1  1 = channel takes part in equality compare
flush  in  1  end of capture: emit pending count, return to IDLE
rle_data  out  DW  encoded word (FIFO head)
rle_valid  out  1  rle_data valid
rle_ready  in  1  consumer accepts word when rle_valid&rle_ready
overflow  out  1  sticky: encoded words were dropped
idle  out  1  state IDLE and FIFO empty

Behaviour:
- Reset, while core_rst=1 at a clock edge: state=IDLE, old=0, cnt=0, FIFO empty, rle_valid=0, rle_data=0, overflow=0, idle=1. Reset mid-run discards the pending count and FIFO contents.
- MAX = 2^(DW-1)-1. Compare: (s & capture_mask) == (old & capture_mask). Literals always carry the full unmasked sample.
- IDLE, capture_valid: push {0,s}; old<=s; cnt<=0; go to RUN.
- RUN, capture_valid, equal:
  - if cnt+1==MAX: push {1,MAX}; cnt<=0.
  - else: cnt<=cnt+1; no push.
  - Count words never carry 0. Consecutive count words sum at the decoder.
- RUN, capture_valid, differs:
  - if cnt!=0, push {1,cnt} then {0,s}, in that order; else push {0,s}.
  - old<=s; cnt<=0.
- capture_valid=0: no state change. Gaps do not break a run.
- flush is evaluated after the same-cycle sample. If state=RUN and the resulting cnt!=0, push {1,cnt}. Then cnt<=0 and state=IDLE. flush in IDLE is a no-op.
- At most 2 pushes per cycle.
- Pushes from one cycle are atomic. If FIFO free slots (after the same-cycle pop) are fewer than the pushes needed:
  - all of that cycle's words are dropped;
  - overflow<=1;
  - old, cnt and state still update as if written.
- overflow clears only on reset.
- FIFO is first-word-fall-through and registered. A word pushed at edge k is visible on rle_data/rle_valid after edge k. Latency is 1 cycle from a sampled input to rle_valid when the FIFO is empty.
- Pop on rle_valid&rle_ready. Simultaneous push and pop at full depth is allowed.
- rle_data is held stable while rle_valid&~rle_ready.
- Pointers wrap modulo 2^FIFO_AW, with one extra bit for full/empty.

Optional Feature:
- Macro: RLE_STATS_EN.
- Defined: adds outputs sample_count[31:0] (capture_valid cycles) and word_count[31:0] (words popped). Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
1. DW=16, mask=0x7FFF, ready=1. Input 0x0005 x5 with one capture_valid=0 gap in the run, then 0x0007, then flush. Output: 0x0005, 0x8004, 0x0007. idle=1 after drain.
2. Input 0x0001 x32769, then flush. Output: 0x0001, 0xFFFF, 0x8001. No 0x8000 word ever.
3. mask=0x7FFE. Input 0x0002, 0x0003, 0x0002, then flush. Output: 0x0002, 0x8002.
4. FIFO_AW=2, rle_ready=0. Input 0x0001..0x0005 on consecutive cycles. overflow=1 after the 5th sample. Raising rle_ready then yields 0x0001..0x0004, with data stable while stalled.
5. Input 0x0009 x4, assert core_rst for 1 cycle, then 0x0009. Next cycle rle_valid=0 and overflow=0. Output is 0x0009 only; no count is emitted.
6. With RLE_STATS_EN: test 1 stimulus gives sample_count=6 and word_count=3. Build also compiles with the macro undefined.
